t_coeff_stream: RTL

Unpacks the three packed public-key polynomials t[0..2] produced by the public-key decode stage into a stream of 12-bit coefficients, one per handshake, for the encapsulation NTT/multiply datapath. On `start` it snapshots all 9216 bits of packed t. It then emits 768 coefficients in order: poly 0 coeff 0 first, through poly 2 coeff 255. It also performs the FIPS 203 encapsulation-key modulus check (every coefficient < q) and reports the result with `done`.

---
 rtl/t_coeff_stream_if.sv | 41 ++++
 rtl/t_coeff_stream.sv | 128 ++++++++++++
 2 files changed

// File: rtl/t_coeff_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : t_coeff_stream_if                                            |
// | Description : Valid/ready coefficient stream carrying one raw 12-bit       |
// |               coefficient of t together with its polynomial/coefficient    |
// |               indices and an end-of-stream marker.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface t_coeff_stream_if #(
  parameter int R_WIDTH = 12,
  parameter int POLY_W  = 2,
  parameter int IDX_W   = 8
) ();
  logic               coeff_valid;
  logic               coeff_ready;
  logic [R_WIDTH-1:0] coeff;
  logic [POLY_W-1:0]  poly_idx;
  logic [IDX_W-1:0]   coeff_idx;
  logic               coeff_last;

  // Producer side: drives the coefficient and its tags, receives ready
  modport master (
    output coeff_valid,
    output coeff,
    output poly_idx,
    output coeff_idx,
    output coeff_last,
    input  coeff_ready
  );

  // Consumer side
  modport slave (
    input  coeff_valid,
    input  coeff,
    input  poly_idx,
    input  coeff_idx,
    input  coeff_last,
    output coeff_ready
  );
endinterface
`default_nettype wire

// File: rtl/t_coeff_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : t_coeff_stream                                               |
// | Description : Snapshots the packed public-key polynomials t[0..K-1] on     |
// |               start and streams their coefficients one per handshake,      |
// |               poly 0 coeff 0 first. Flags any coefficient >= q and reports |
// |               the result alongside a one-cycle done pulse.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module t_coeff_stream #(
  parameter int KYBER_K       = 3,
  parameter int KYBER_N       = 256,
  parameter int KYBER_R_WIDTH = 12,
  parameter int KYBER_Q       = 3329
) (
  input  wire                                      clk,
  input  wire                                      rst_n,
  input  wire                                      start,
  input  wire  [KYBER_K*KYBER_R_WIDTH*KYBER_N-1:0] t_in,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     pk_invalid,
  t_coeff_stream_if.master                         cs
);

  localparam int c_T_WIDTH = KYBER_K * KYBER_R_WIDTH * KYBER_N;
  localparam int c_POLY_W  = $clog2(KYBER_K);
  localparam int c_IDX_W   = $clog2(KYBER_N);

  localparam logic [c_POLY_W-1:0]      c_LAST_POLY  = c_POLY_W'(KYBER_K - 1);
  localparam logic [c_IDX_W-1:0]       c_LAST_COEFF = c_IDX_W'(KYBER_N - 1);
  localparam logic [KYBER_R_WIDTH-1:0] c_Q          = KYBER_R_WIDTH'(KYBER_Q);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // The snapshot is consumed as a shift register: the current coefficient is
  // always in the low bits, which avoids a 768-way read mux.
  logic [c_T_WIDTH-1:0]     r_t;
  logic [c_POLY_W-1:0]      r_poly_idx;
  logic [c_IDX_W-1:0]       r_coeff_idx;
  logic                     r_pk_invalid;

  logic                     w_streaming;
  logic                     w_start_acc;
  logic                     w_hs;
  logic                     w_last;
  logic [KYBER_R_WIDTH-1:0] w_coeff;
  logic                     w_coeff_bad;

  assign w_streaming = (r_state == S_STREAM);
  // Only an idle block accepts start; this also rejects start in the done cycle
  assign w_start_acc = start && (r_state == S_IDLE);
  assign w_hs        = w_streaming && cs.coeff_ready;
  assign w_last      = w_streaming && (r_poly_idx == c_LAST_POLY) &&
                       (r_coeff_idx == c_LAST_COEFF);
  assign w_coeff     = w_streaming ? r_t[KYBER_R_WIDTH-1:0] : '0;
  assign w_coeff_bad = (w_coeff >= c_Q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_STREAM;
      S_STREAM: if (w_hs && w_last) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Snapshot capture on start, shift one coefficient out per handshake
  always_ff @(posedge clk) begin
    if (w_start_acc) begin
      r_t <= t_in;
    end else if (w_hs) begin
      r_t <= {{KYBER_R_WIDTH{1'b0}}, r_t[c_T_WIDTH-1:KYBER_R_WIDTH]};
    end
  end

  // Index counters and sticky range-check flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_poly_idx   <= '0;
      r_coeff_idx  <= '0;
      r_pk_invalid <= 1'b0;
    end else if (w_start_acc) begin
      r_poly_idx   <= '0;
      r_coeff_idx  <= '0;
      r_pk_invalid <= 1'b0;
    end else if (w_hs) begin
      r_pk_invalid <= r_pk_invalid | w_coeff_bad;
      if (r_coeff_idx == c_LAST_COEFF) begin
        r_coeff_idx <= '0;
        // Wrap to 0 after the final poly so the index never leaves 0..K-1
        r_poly_idx  <= w_last ? '0 : r_poly_idx + 1'b1;
      end else begin
        r_coeff_idx <= r_coeff_idx + 1'b1;
      end
    end
  end

  assign cs.coeff_valid = w_streaming;
  assign cs.coeff       = w_coeff;
  assign cs.poly_idx    = r_poly_idx;
  assign cs.coeff_idx   = r_coeff_idx;
  assign cs.coeff_last  = w_last;

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FINISH);
  assign pk_invalid = r_pk_invalid;

endmodule
`default_nettype wire
